// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter: four-lane round-robin arbiter with a per-grant burst
// limit, driving a 4:1 data mux into a registered valid/ready output stage.
module mux_4x1_rr_arbiter #(
  parameter int LEN     = 8,
  parameter int BURST   = 4,
  parameter int BURST_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [LEN-1:0] in0,
  input  logic [LEN-1:0] in1,
  input  logic [LEN-1:0] in2,
  input  logic [LEN-1:0] in3,
  output logic [3:0]     ack,
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic           out_valid,
  output logic [LEN-1:0] out_data,
  output logic [1:0]     out_src,
  input  logic           out_ready
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         sel_q, sel_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [LEN-1:0]     out_data_q, out_data_d;
  logic [1:0]         out_src_q, out_src_d;

  logic [1:0]         win_idx;
  logic [LEN-1:0]     mux_data;
  logic               space;
  logic               load;
  logic               burst_last;
  logic               rel_grant;

  // Scanned from the farthest offset down so the lane closest to ptr wins.
  always_comb begin
    win_idx = ptr_q;
    for (int unsigned i = 4; i > 0; i--) begin
      if (req[ptr_q + 2'(i - 1)]) begin
        win_idx = ptr_q + 2'(i - 1);
      end
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    mux_data = in0;
      2'd1:    mux_data = in1;
      2'd2:    mux_data = in2;
      default: mux_data = in3;
    endcase
  end

  always_comb begin
    space      = !out_valid_q || out_ready;
    load       = (state_q == GRANT) && req[sel_q] && space;
    burst_last = (burst_cnt_q == BURST_W'(BURST - 1));
    rel_grant  = (state_q == GRANT) &&
                 ((!req[sel_q] && !load) || (load && burst_last));
    gnt        = (state_q == GRANT) ? (4'b0001 << sel_q) : '0;
    ack        = load ? (4'b0001 << sel_q) : '0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d       = win_idx;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (load) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
        if (rel_grant) begin
          ptr_d       = sel_q + 2'd1;
          burst_cnt_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = sel_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/mux_4x1_rr_arbiter.md
# mux_4x1_rr_arbiter

Round-robin arbiter and output stage for a four-requester, LEN-bit shared channel. It arbitrates four request lines and drives the select of an internal 4:1 LEN-bit select mux. Each winner may send up to BURST consecutive words before the grant rotates. Each accepted word is captured into a registered valid/ready output port. It sits between four producer lanes (e.g. PE or bus ports) and one downstream consumer.

## Interface
- LEN, 8, data width of each input and of out_data
- BURST, 4, max words per grant (>=1)
- BURST_W, 2, width of burst counter; must satisfy 2**BURST_W >= BURST
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req  input  4  req[i]=1: lane i has a valid word on in<i>
- in0..in3  input  LEN each  lane data
- ack  output  4  one-hot; ack[i]=1 in the cycle lane i's word is captured; lane advances its data next cycle
- gnt  output  4  one-hot current grant, 0 when idle
- sel  output  2  registered grant index driving the mux
- out_valid  output  1  output register holds a word
- out_data  output  LEN  captured word
- out_src  output  2  lane index of out_data
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready

## Operation
- Reset values (next edge after reset=1): state=IDLE, ptr=0, sel=0, burst_cnt=0, gnt=0, ack=0, out_valid=0, out_data=0, out_src=0. Reset mid-burst or mid-stall discards the held word.
- ptr is the highest-priority lane. Pick order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first lane with req=1 wins.
- IDLE: if req!=0, set sel=winner, burst_cnt=0, go to GRANT. Else stay. gnt=0 and no load in IDLE.
- GRANT: gnt = one-hot(sel).
- space = !out_valid || out_ready.
- load = req[sel] && space.
- ack = load ? one-hot(sel) : 0.
- On load:
  - out_data <= mux(sel), out_src <= sel, out_valid <= 1.
  - burst_cnt <= burst_cnt+1.
- Otherwise, if out_ready, out_valid <= 0.
- Release from GRANT occurs on either:
  - (a) !req[sel], with no load that cycle, or
  - (b) load && burst_cnt==BURST-1.
- On release: ptr <= sel+1 mod 4, burst_cnt <= 0, go to IDLE. Every release costs exactly one IDLE (arbitration) cycle.
- Stall: out_valid && !out_ready gives no load. burst_cnt and grant hold. Release (a) still applies if the granted lane drops req.
- Simultaneous drain and load (out_ready=1, out_valid=1, load=1): the register is replaced and out_valid stays 1 (full throughput within a burst).
- BURST=1: release after every word.
- Requests from non-granted lanes never produce ack. Lanes must hold req and data stable until ack.

## Timing
- The req edge is sampled in IDLE at cycle N. gnt/sel are valid at N+1. The earliest ack is at N+1. out_valid rises at N+2.
- Within a grant with out_ready=1: one word per cycle, BURST words in BURST consecutive cycles, then one IDLE cycle.
- Worst-case wait for a continuously requesting lane: 3*(BURST+1) cycles, plus output stall cycles.
- ack, gnt and sel derive from registered state and current req/out_ready only. There is no combinational path from in* to any control output.

## Test plan
- Reset: hold reset=1 for 2 cycles with req=4'b1111 -> all outputs 0. After release: gnt=4'b0001 one cycle later, sel=0.
- Single lane burst (BURST=4): req=4'b0100 held, in2 = 0x10,0x11,… advancing on ack, out_ready=1 -> ack[2] for 4 consecutive cycles, out_data 0x10..0x13, then one cycle gnt=0, then a new grant to lane 2.
- Rotation: req=4'b1111 held, out_ready=1 -> grant order lanes 0,1,2,3,0. 4 words each. out_src sequence matches. Exactly one IDLE cycle between grants.
- Early release: lane 1 granted; it drops req after 2 acks -> release with no third ack. ptr=2. Lane 3 (req=1) granted next even though lane 0 is also requesting.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data/out_valid held, ack=0, burst_cnt frozen. On out_ready=1, load resumes the same cycle; total words per grant is still 4.
- Reset mid-burst: assert reset at word 2 of a grant -> next cycle all outputs 0. After reset, arbitration restarts from ptr=0.
